// File: rtl/mccpu_pkg.sv
// Shared types, ISA constants and combinational helpers for the multi-cycle MIPS core.
package mccpu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT,
    ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;

  typedef enum logic [3:0] {
    K_ALU_R, K_ALU_I, K_LOAD, K_STORE, K_BEQ, K_BNE, K_J, K_JAL, K_JR
  } kind_t;

  typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_LUI} ext_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} msize_t;

  typedef struct packed {
    logic    legal;
    kind_t   kind;
    alu_op_t alu_op;
    ext_t    ext;
    msize_t  size;
    logic    uns;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d       = '0;
    d.size  = SZ_W;
    d.legal = 1'b1;
    case (op)
      OP_RTYPE: begin
        d.kind = K_ALU_R;
        case (fn)
          FN_ADDU: d.alu_op = ALU_ADD;
          FN_SUBU: d.alu_op = ALU_SUB;
          FN_AND:  d.alu_op = ALU_AND;
          FN_OR:   d.alu_op = ALU_OR;
          FN_NOR:  d.alu_op = ALU_NOR;
          FN_SLT:  d.alu_op = ALU_SLT;
          FN_SLTU: d.alu_op = ALU_SLTU;
          FN_SLL:  d.alu_op = ALU_SLL;
          FN_SRL:  d.alu_op = ALU_SRL;
          FN_SRA:  d.alu_op = ALU_SRA;
          FN_JR:   d.kind   = K_JR;
          default: d.legal  = 1'b0;
        endcase
      end
      OP_ADDIU: begin d.kind = K_ALU_I; d.alu_op = ALU_ADD; end
      OP_SLTI:  begin d.kind = K_ALU_I; d.alu_op = ALU_SLT; end
      OP_ANDI:  begin d.kind = K_ALU_I; d.alu_op = ALU_AND; d.ext = EXT_ZERO; end
      OP_ORI:   begin d.kind = K_ALU_I; d.alu_op = ALU_OR;  d.ext = EXT_ZERO; end
      OP_LUI:   begin d.kind = K_ALU_I; d.alu_op = ALU_LUI; d.ext = EXT_LUI; end
      OP_LB:    begin d.kind = K_LOAD;  d.size = SZ_B; end
      OP_LBU:   begin d.kind = K_LOAD;  d.size = SZ_B; d.uns = 1'b1; end
      OP_LH:    begin d.kind = K_LOAD;  d.size = SZ_H; end
      OP_LHU:   begin d.kind = K_LOAD;  d.size = SZ_H; d.uns = 1'b1; end
      OP_LW:    d.kind = K_LOAD;
      OP_SB:    begin d.kind = K_STORE; d.size = SZ_B; end
      OP_SH:    begin d.kind = K_STORE; d.size = SZ_H; end
      OP_SW:    d.kind = K_STORE;
      OP_BEQ:   d.kind = K_BEQ;
      OP_BNE:   d.kind = K_BNE;
      OP_J:     d.kind = K_J;
      OP_JAL:   d.kind = K_JAL;
      default:  d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] ext_imm(input ext_t mode, input logic [15:0] imm);
    case (mode)
      EXT_ZERO: return {16'h0000, imm};
      EXT_LUI:  return {imm, 16'h0000};
      default:  return {{16{imm[15]}}, imm};
    endcase
  endfunction

  function automatic logic [31:0] alu_calc(input alu_op_t op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
    case (op)
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return b << sh;
      ALU_SRL:  return b >> sh;
      ALU_SRA:  return $signed(b) >>> sh;
      ALU_LUI:  return b;
      default:  return a + b;
    endcase
  endfunction

endpackage

// File: rtl/mccpu_lsu.sv
// Load/store lane handling: byte enables, replicated store data, load extraction and alignment check.
module mccpu_lsu
  import mccpu_pkg::*;
(
  input  msize_t      size,
  input  logic        uns,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
  assign lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be         = 4'hF;
    wdata      = store_data;
    load_data  = rdata;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = uns ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      SZ_H: begin
        be         = addr_lo[1] ? 4'hC : 4'h3;
        wdata      = {2{store_data[15:0]}};
        load_data  = uns ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
        misaligned = addr_lo[0];
      end
      default: misaligned = |addr_lo;
    endcase
  end

endmodule

// File: rtl/mccpu.sv
// Multi-cycle MIPS core: FSM-sequenced Fetch/Decode/Execute/Memory/Writeback over one
// handshaked memory port, with illegal/misaligned halt and a retired-instruction counter.
module mccpu
  import mccpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  input  logic [4:0]       reg_sel,
  output logic [31:0]      reg_data
);

  state_t      state, state_n;
  logic [31:0] pc, pc4, ir, a_q, b_q, imm_q, alu_out, mdr;
  logic [31:0] rf [32];

  dec_t        dec;
  logic [31:0] imm32, alu_b, alu_res;
  logic [3:0]  lsu_be;
  logic [31:0] lsu_wdata, lsu_load;
  logic        lsu_mis;

  logic        pc_we, ir_we, ab_we, alu_we, mdr_we, rf_we, retire;
  logic [31:0] pc_n, rf_wdata;
  logic [4:0]  rf_waddr;
  logic        req_n, we_n;
  logic [3:0]  be_n;
  logic [31:0] addr_n, wdata_n;

  // IR is held for the whole instruction, so control is decoded from it every cycle.
  assign dec      = decode(ir[31:26], ir[5:0]);
  assign imm32    = ext_imm(dec.ext, ir[15:0]);
  assign alu_b    = (dec.kind == K_ALU_R) ? b_q : imm_q;
  assign alu_res  = alu_calc(dec.alu_op, a_q, alu_b, ir[10:6]);
  assign halted   = (state == HALT);
  assign reg_data = rf[reg_sel];
  assign retire   = (state_n == FETCH) && (state != FETCH);

  mccpu_lsu u_lsu (
    .size       (dec.size),
    .uns        (dec.uns),
    .addr_lo    (alu_out[1:0]),
    .store_data (b_q),
    .rdata      (mem_rdata),
    .be         (lsu_be),
    .wdata      (lsu_wdata),
    .load_data  (lsu_load),
    .misaligned (lsu_mis)
  );

  always_comb begin
    state_n  = state;
    pc_we    = 1'b0;
    pc_n     = pc4;
    ir_we    = 1'b0;
    ab_we    = 1'b0;
    alu_we   = 1'b0;
    mdr_we   = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = alu_out;
    req_n    = mem_req;
    we_n     = mem_we;
    be_n     = mem_be;
    addr_n   = mem_addr;
    wdata_n  = mem_wdata;
    case (state)
      FETCH: begin
        if (!mem_req) begin
          req_n  = 1'b1;
          we_n   = 1'b0;
          be_n   = 4'hF;
          addr_n = pc;
        end else if (mem_ready) begin
          req_n   = 1'b0;
          ir_we   = 1'b1;
          state_n = DECODE;
        end
      end
      DECODE: begin
        ab_we   = 1'b1;
        state_n = dec.legal ? EXEC : HALT;
      end
      EXEC: begin
        alu_we  = 1'b1;
        state_n = WB;
        case (dec.kind)
          K_BEQ, K_BNE: begin
            pc_we = 1'b1;
            if ((a_q == b_q) == (dec.kind == K_BEQ))
              pc_n = pc4 + {imm_q[29:0], 2'b00};
            state_n = FETCH;
          end
          K_J, K_JAL: begin
            pc_we   = 1'b1;
            pc_n    = {pc4[31:28], ir[25:0], 2'b00};
            rf_we   = (dec.kind == K_JAL);
            rf_waddr = 5'd31;
            rf_wdata = pc4;
            state_n = FETCH;
          end
          K_JR: begin
            pc_we   = 1'b1;
            pc_n    = a_q;
            state_n = FETCH;
          end
          K_LOAD, K_STORE: state_n = MEM;
          default: ;
        endcase
      end
      MEM: begin
        if (!mem_req) begin
          if (lsu_mis) begin
            state_n = HALT;
          end else begin
            req_n   = 1'b1;
            we_n    = (dec.kind == K_STORE);
            be_n    = lsu_be;
            addr_n  = {alu_out[31:2], 2'b00};
            wdata_n = lsu_wdata;
          end
        end else if (mem_ready) begin
          req_n = 1'b0;
          if (dec.kind == K_STORE) begin
            pc_we   = 1'b1;
            state_n = FETCH;
          end else begin
            mdr_we  = 1'b1;
            state_n = WB;
          end
        end
      end
      WB: begin
        rf_we    = 1'b1;
        rf_waddr = (dec.kind == K_ALU_R) ? ir[15:11] : ir[20:16];
        rf_wdata = (dec.kind == K_LOAD) ? mdr : alu_out;
        pc_we    = 1'b1;
        state_n  = FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      pc4       <= '0;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      retired   <= '0;
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      state     <= state_n;
      mem_req   <= req_n;
      mem_we    <= we_n;
      mem_be    <= be_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      if (pc_we)  pc <= pc_n;
      if (ir_we) begin
        ir  <= mem_rdata;
        pc4 <= pc + 32'd4;
      end
      if (ab_we) begin
        a_q   <= rf[ir[25:21]];
        b_q   <= rf[ir[20:16]];
        imm_q <= imm32;
      end
      if (alu_we) alu_out <= alu_res;
      if (mdr_we) mdr <= lsu_load;
      if (rf_we && (rf_waddr != 5'd0)) rf[rf_waddr] <= rf_wdata;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mccpu.sv
// Directed bench for mccpu: small hand-assembled programs against a wait-state memory model.
module tb_mccpu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we, halted;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, reg_data;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] retired;
  logic [4:0]  reg_sel = '0;

  int errors = 0;
  int checks = 0;
  int wait_states = 0;
  int wcnt = 0;
  logic [31:0] mem [0:4095];

  mccpu #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halted(halted), .retired(retired), .reg_sel(reg_sel), .reg_data(reg_data)
  );

  always #5 clk = ~clk;

  // Memory answers on the falling edge after wait_states idle falling edges.
  always @(negedge clk) begin
    if (!rst) begin
      mem_ready <= 1'b0;
      wcnt      <= 0;
    end else if (mem_req && !mem_ready) begin
      if (wcnt >= wait_states) begin
        mem_ready <= 1'b1;
        wcnt      <= 0;
        mem_rdata <= mem[mem_addr[13:2]];
        if (mem_we)
          for (int k = 0; k < 4; k++)
            if (mem_be[k]) mem[mem_addr[13:2]][8*k +: 8] = mem_wdata[8*k +: 8];
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      mem_ready <= 1'b0;
    end
  end

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] target);
    return {op, target[27:2]};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold_reset(input int ws);
    rst = 1'b0;
    wait_states = ws;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    step(2);
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    mem[12'hC00 + idx] = w;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_retired(input int n, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step(1);
      if (retired >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    hold_reset(0);
    put(0, enc_j(6'h02, 32'h3000));
    checks++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, halted} !== '0)
      $display("FAIL reset_outputs: got req=%b we=%b be=%h addr=%h wdata=%h halted=%b expected all zero",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, halted);
    checks++;
    if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, halted} !== '0) errors++;
    release_reset();
    step(1);
    checks++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h3000}) begin
      errors++;
      $display("FAIL first_fetch: got req=%b we=%b be=%h addr=%h expected req=1 we=0 be=f addr=00003000",
               mem_req, mem_we, mem_be, mem_addr);
    end
    checks++;
    if (retired !== 32'd0) begin errors++; $display("FAIL first_fetch_retired: got %0d expected 0", retired); end
  endtask

  task automatic test_alu_basic();
    hold_reset(0);
    put(0, enc_i(6'h0D, 5'd0, 5'd1, 16'h1234));
    put(1, enc_r(6'h21, 5'd1, 5'd1, 5'd2, 5'd0));
    put(2, enc_j(6'h02, 32'h3008));
    release_reset();
    step(9);
    checks++;
    if (retired !== 32'd1) begin errors++; $display("FAIL alu_retired_9: got %0d expected 1", retired); end
    step(1);
    checks++;
    if (retired !== 32'd2) begin errors++; $display("FAIL alu_retired_10: got %0d expected 2", retired); end
    reg_sel = 5'd2;
    #1;
    checks++;
    if (reg_data !== 32'h2468) begin errors++; $display("FAIL alu_addu: got %h expected 00002468", reg_data); end
  endtask

  task automatic test_alu_ops();
    logic [4:0]  r [15];
    logic [31:0] e [15];
    bit ok;
    hold_reset(0);
    put(0,  enc_i(6'h09, 5'd0, 5'd3, 16'hFFFB));
    put(1,  enc_i(6'h0F, 5'd0, 5'd4, 16'h8000));
    put(2,  enc_r(6'h23, 5'd0, 5'd3, 5'd5, 5'd0));
    put(3,  enc_r(6'h2A, 5'd3, 5'd5, 5'd6, 5'd0));
    put(4,  enc_r(6'h2B, 5'd3, 5'd5, 5'd7, 5'd0));
    put(5,  enc_r(6'h03, 5'd0, 5'd4, 5'd8, 5'd4));
    put(6,  enc_r(6'h02, 5'd0, 5'd4, 5'd9, 5'd4));
    put(7,  enc_r(6'h00, 5'd0, 5'd5, 5'd10, 5'd3));
    put(8,  enc_r(6'h27, 5'd0, 5'd0, 5'd11, 5'd0));
    put(9,  enc_i(6'h0C, 5'd3, 5'd12, 16'hFF00));
    put(10, enc_r(6'h25, 5'd5, 5'd10, 5'd13, 5'd0));
    put(11, enc_i(6'h0A, 5'd3, 5'd14, 16'hFFFC));
    put(12, enc_r(6'h21, 5'd5, 5'd5, 5'd0, 5'd0));
    put(13, enc_r(6'h24, 5'd3, 5'd13, 5'd15, 5'd0));
    put(14, enc_j(6'h02, 32'h3038));
    r = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd15, 5'd1};
    e = '{32'hFFFFFFFB, 32'h80000000, 32'h5, 32'h1, 32'h0, 32'hF8000000, 32'h08000000, 32'h28,
          32'hFFFFFFFF, 32'h0000FF00, 32'h2D, 32'h1, 32'h0, 32'h29, 32'h0};
    release_reset();
    wait_retired(14, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL alu_ops_timeout: retired=%0d expected 14", retired); end
    for (int i = 0; i < 15; i++) begin
      reg_sel = r[i];
      #1;
      checks++;
      if (reg_data !== e[i]) begin
        errors++;
        $display("FAIL alu_ops_r%0d: got %h expected %h", r[i], reg_data, e[i]);
      end
    end
  endtask

  task automatic test_branch_jump();
    logic [4:0]  r [5];
    logic [31:0] e [5];
    bit ok;
    hold_reset(0);
    put(0, enc_i(6'h09, 5'd0, 5'd1, 16'h0001));
    put(1, enc_i(6'h04, 5'd1, 5'd0, 16'h0001));
    put(2, enc_i(6'h05, 5'd1, 5'd0, 16'h0001));
    put(3, enc_i(6'h09, 5'd0, 5'd2, 16'h0077));
    put(4, enc_j(6'h03, 32'h3020));
    put(5, enc_i(6'h09, 5'd0, 5'd3, 16'h0055));
    put(6, enc_j(6'h02, 32'h3018));
    put(8, enc_i(6'h09, 5'd0, 5'd4, 16'h0066));
    put(9, enc_r(6'h08, 5'd31, 5'd0, 5'd0, 5'd0));
    r = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd31};
    e = '{32'h1, 32'h0, 32'h55, 32'h66, 32'h3014};
    release_reset();
    wait_retired(8, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL branch_timeout: retired=%0d expected 8", retired); end
    for (int i = 0; i < 5; i++) begin
      reg_sel = r[i];
      #1;
      checks++;
      if (reg_data !== e[i]) begin
        errors++;
        $display("FAIL branch_r%0d: got %h expected %h", r[i], reg_data, e[i]);
      end
    end
  endtask

  // addiu, beq (not taken), sw, lw, j: one, one, two, two, one memory access.
  task automatic test_latency(input int w);
    int exp_gap [5];
    int last_edge, n_ret, edge_no;
    logic [31:0] prev_ret;
    logic prev_req;
    logic [68:0] snap;
    exp_gap = '{5 + w, 4 + w, 6 + 2*w, 7 + 2*w, 4 + w};
    hold_reset(w);
    put(0, enc_i(6'h09, 5'd0, 5'd1, 16'h0100));
    put(1, enc_i(6'h04, 5'd0, 5'd1, 16'h0001));
    put(2, enc_i(6'h2B, 5'd0, 5'd1, 16'h0040));
    put(3, enc_i(6'h23, 5'd0, 5'd2, 16'h0040));
    put(4, enc_j(6'h02, 32'h3010));
    last_edge = 0;
    n_ret = 0;
    prev_ret = '0;
    prev_req = 1'b0;
    snap = '0;
    release_reset();
    for (edge_no = 1; edge_no <= 300 && n_ret < 5; edge_no++) begin
      step(1);
      if (mem_req && prev_req) begin
        checks++;
        if ({mem_we, mem_be, mem_addr, mem_wdata} !== snap) begin
          errors++;
          $display("FAIL hold_w%0d: got %h expected %h", w, {mem_we, mem_be, mem_addr, mem_wdata}, snap);
        end
      end
      if (mem_req && !prev_req) snap = {mem_we, mem_be, mem_addr, mem_wdata};
      prev_req = mem_req;
      if (retired !== prev_ret) begin
        checks++;
        if (edge_no - last_edge != exp_gap[n_ret]) begin
          errors++;
          $display("FAIL latency_w%0d_i%0d: got %0d cycles expected %0d", w, n_ret, edge_no - last_edge, exp_gap[n_ret]);
        end
        last_edge = edge_no;
        prev_ret = retired;
        n_ret++;
      end
    end
    checks++;
    if (n_ret != 5) begin errors++; $display("FAIL latency_w%0d_timeout: got %0d retirements expected 5", w, n_ret); end
    reg_sel = 5'd2;
    #1;
    checks++;
    if (reg_data !== 32'h100) begin errors++; $display("FAIL latency_w%0d_lw: got %h expected 00000100", w, reg_data); end
  endtask

  task automatic test_byte_lanes();
    logic [4:0]  r [5];
    logic [31:0] e [5];
    logic [67:0] st [2];
    logic [67:0] st_exp [2];
    int n_st;
    logic prev_req;
    hold_reset(0);
    put(0, enc_i(6'h0D, 5'd0, 5'd1, 16'h80AB));
    put(1, enc_i(6'h28, 5'd0, 5'd1, 16'h0001));
    put(2, enc_i(6'h20, 5'd0, 5'd2, 16'h0001));
    put(3, enc_i(6'h24, 5'd0, 5'd3, 16'h0001));
    put(4, enc_i(6'h29, 5'd0, 5'd1, 16'h0002));
    put(5, enc_i(6'h21, 5'd0, 5'd4, 16'h0002));
    put(6, enc_i(6'h25, 5'd0, 5'd5, 16'h0002));
    put(7, enc_i(6'h23, 5'd0, 5'd6, 16'h0000));
    put(8, enc_j(6'h02, 32'h3020));
    r = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
    e = '{32'hFFFFFFAB, 32'h000000AB, 32'hFFFF80AB, 32'h000080AB, 32'h80ABAB00};
    st_exp = '{{4'b0010, 32'h0, 32'hABABABAB}, {4'b1100, 32'h0, 32'h80AB80AB}};
    st = '{68'h0, 68'h0};
    n_st = 0;
    prev_req = 1'b0;
    release_reset();
    for (int i = 0; i < 300 && retired < 8; i++) begin
      step(1);
      if (mem_req && !prev_req && mem_we && n_st < 2) begin
        st[n_st] = {mem_be, mem_addr, mem_wdata};
        n_st++;
      end
      prev_req = mem_req;
    end
    checks++;
    if (retired !== 32'd8) begin errors++; $display("FAIL lanes_timeout: retired=%0d expected 8", retired); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (st[i] !== st_exp[i]) begin
        errors++;
        $display("FAIL lanes_store%0d: got be/addr/wdata %h expected %h", i, st[i], st_exp[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      reg_sel = r[i];
      #1;
      checks++;
      if (reg_data !== e[i]) begin
        errors++;
        $display("FAIL lanes_r%0d: got %h expected %h", r[i], reg_data, e[i]);
      end
    end
  endtask

  // One good instruction, then a bad one: only two fetches ever reach memory.
  task automatic test_halt(input logic [31:0] bad, input string tag);
    int n_req;
    logic prev_req;
    hold_reset(0);
    put(0, enc_i(6'h09, 5'd0, 5'd7, 16'h0001));
    put(1, bad);
    put(2, enc_i(6'h09, 5'd0, 5'd8, 16'h0001));
    n_req = 0;
    prev_req = 1'b0;
    release_reset();
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (mem_req && !prev_req) n_req++;
      prev_req = mem_req;
    end
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_%s_flag: got %b expected 1", tag, halted); end
    checks++;
    if (retired !== 32'd1) begin errors++; $display("FAIL halt_%s_retired: got %0d expected 1", tag, retired); end
    checks++;
    if (n_req != 2 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL halt_%s_requests: got %0d requests (req=%b) expected 2 (req=0)", tag, n_req, mem_req);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int guard;
    hold_reset(0);
    put(0, enc_i(6'h0D, 5'd0, 5'd1, 16'h1234));
    put(1, enc_r(6'h21, 5'd1, 5'd1, 5'd2, 5'd0));
    put(2, enc_j(6'h02, 32'h3008));
    release_reset();
    wait_retired(1, 50, ok);
    guard = 0;
    while (!mem_req && guard < 20) begin
      step(1);
      guard++;
    end
    checks++;
    if (!ok || !mem_req) begin errors++; $display("FAIL midreset_setup: got req=%b retired=%0d expected req=1", mem_req, retired); end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL midreset_req: got %b expected 0", mem_req); end
    checks++;
    if (retired !== 32'd0) begin errors++; $display("FAIL midreset_retired: got %0d expected 0", retired); end
    reg_sel = 5'd1;
    #1;
    checks++;
    if (reg_data !== 32'h0) begin errors++; $display("FAIL midreset_rf: got %h expected 00000000", reg_data); end
    step(2);
    release_reset();
    step(1);
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h3000}) begin
      errors++;
      $display("FAIL midreset_refetch: got req=%b addr=%h expected req=1 addr=00003000", mem_req, mem_addr);
    end
    step(9);
    reg_sel = 5'd2;
    #1;
    checks++;
    if (reg_data !== 32'h2468) begin errors++; $display("FAIL midreset_rerun: got %h expected 00002468", reg_data); end
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_alu_ops();
    test_branch_jump();
    test_latency(0);
    test_latency(3);
    test_byte_lanes();
    test_halt(enc_i(6'h23, 5'd0, 5'd1, 16'h0002), "lw");
    test_halt(enc_i(6'h29, 5'd0, 5'd1, 16'h0001), "sh");
    test_halt(32'hFC00_0000, "op3f");
    test_halt(enc_r(6'h3F, 5'd1, 5'd1, 5'd1, 5'd0), "fn3f");
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
